// File: rtl/rv64g_l1_dcache.sv
// rtl/rv64g_l1_dcache.sv - Direct-mapped write-back L1 data cache with a TileLink TL-C client port.
module rv64g_l1_dcache #(
  parameter int unsigned SETS      = 64,
  parameter logic [3:0]  SOURCE_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        invalidate_all_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  be_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [63:0] rdata_o,
  output logic        tl_a_valid_o,
  input  logic        tl_a_ready_i,
  output logic [2:0]  tl_a_opcode_o,
  output logic [2:0]  tl_a_param_o,
  output logic [3:0]  tl_a_size_o,
  output logic [3:0]  tl_a_source_o,
  output logic [63:0] tl_a_address_o,
  output logic [7:0]  tl_a_mask_o,
  output logic [63:0] tl_a_data_o,
  output logic        tl_a_corrupt_o,
  input  logic        tl_b_valid_i,
  output logic        tl_b_ready_o,
  input  logic [2:0]  tl_b_opcode_i,
  input  logic [2:0]  tl_b_param_i,
  input  logic [3:0]  tl_b_size_i,
  input  logic [3:0]  tl_b_source_i,
  input  logic [63:0] tl_b_address_i,
  input  logic [7:0]  tl_b_mask_i,
  input  logic [63:0] tl_b_data_i,
  input  logic        tl_b_corrupt_i,
  output logic        tl_c_valid_o,
  input  logic        tl_c_ready_i,
  output logic [2:0]  tl_c_opcode_o,
  output logic [2:0]  tl_c_param_o,
  output logic [3:0]  tl_c_size_o,
  output logic [3:0]  tl_c_source_o,
  output logic [63:0] tl_c_address_o,
  output logic [63:0] tl_c_data_o,
  output logic        tl_c_corrupt_o,
  input  logic        tl_d_valid_i,
  output logic        tl_d_ready_o,
  input  logic [2:0]  tl_d_opcode_i,
  input  logic [1:0]  tl_d_param_i,
  input  logic [3:0]  tl_d_size_i,
  input  logic [3:0]  tl_d_source_i,
  input  logic [3:0]  tl_d_sink_i,
  input  logic        tl_d_denied_i,
  input  logic [63:0] tl_d_data_i,
  input  logic        tl_d_corrupt_i,
  output logic        tl_e_valid_o,
  input  logic        tl_e_ready_i,
  output logic [3:0]  tl_e_sink_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 64 - 6 - IDX_W;

  localparam logic [2:0] A_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] C_PROBE_ACK = 3'd4, C_PROBE_ACK_DATA = 3'd5;
  localparam logic [2:0] C_RELEASE = 3'd6, C_RELEASE_DATA = 3'd7;
  localparam logic [2:0] D_GRANT = 3'd4, D_GRANT_DATA = 3'd5, D_RELEASE_ACK = 3'd6;
  localparam logic [2:0] G_NTOB = 3'd0, G_NTOT = 3'd1, G_BTOT = 3'd2;
  localparam logic [2:0] CAP_TOT = 3'd0, CAP_TOB = 3'd1, CAP_TON = 3'd2;
  localparam logic [2:0] R_TTOB = 3'd0, R_TTON = 3'd1, R_BTON = 3'd2;
  localparam logic [2:0] R_TTOT = 3'd3, R_BTOB = 3'd4, R_NTON = 3'd5;
  localparam logic [3:0] XFER_SIZE = 4'd6;

  localparam logic [1:0] PERM_N = 2'd0, PERM_B = 2'd1, PERM_T = 2'd2;

  localparam logic [2:0] S_IDLE = 3'd0, S_EVICT_C = 3'd1, S_EVICT_WAIT_D = 3'd2, S_ACQ_A = 3'd3;
  localparam logic [2:0] S_ACQ_D = 3'd4, S_GRANT_E = 3'd5, S_PROBE_C = 3'd6, S_RESP = 3'd7;

  logic [2:0]       state;
  logic [2:0]       beat;
  logic             req_we;
  logic [7:0]       req_be;
  logic [63:0]      req_addr;
  logic [63:0]      req_wdata;
  logic [2:0]       prb_param;
  logic [3:0]       prb_source;
  logic [63:0]      prb_addr;
  logic [3:0]       grant_sink;
  logic             grant_denied;

  logic [TAG_W-1:0] tag_q  [SETS];
  logic [1:0]       perm_q [SETS];
  logic [SETS-1:0]  dirty_q;
  logic [63:0]      data_q [SETS][8];

  logic [IDX_W-1:0] in_idx, req_idx, prb_idx;
  logic [TAG_W-1:0] in_tag, req_tag, prb_tag;
  logic [2:0]       req_word;
  logic             in_match, in_hit, in_victim;
  logic             c_has_data, c_last;
  logic             acq_beat_wr, acq_final, acq_grant_t;
  logic [63:0]      acq_base;
  logic             prb_present;
  logic [2:0]       prb_report;
  logic [1:0]       prb_new_perm;

  logic unused_inputs;
  assign unused_inputs = ^{tl_b_opcode_i, tl_b_size_i, tl_b_mask_i, tl_b_data_i, tl_b_corrupt_i,
                           tl_d_size_i, tl_d_source_i, tl_d_corrupt_i, addr_i[2:0], req_addr[2:0]};

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] be);
    logic [63:0] res;
    res = old;
    for (int b = 0; b < 8; b++)
      if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  assign in_idx   = addr_i[6 +: IDX_W];
  assign in_tag   = addr_i[63 -: TAG_W];
  assign req_idx  = req_addr[6 +: IDX_W];
  assign req_tag  = req_addr[63 -: TAG_W];
  assign req_word = req_addr[5:3];
  assign prb_idx  = prb_addr[6 +: IDX_W];
  assign prb_tag  = prb_addr[63 -: TAG_W];

  assign in_match  = (perm_q[in_idx] != PERM_N) && (tag_q[in_idx] == in_tag);
  assign in_hit    = in_match && (!we_i || perm_q[in_idx] == PERM_T);
  assign in_victim = (perm_q[in_idx] != PERM_N) && (tag_q[in_idx] != in_tag);

  assign acq_beat_wr = (state == S_ACQ_D) && tl_d_valid_i && (tl_d_opcode_i == D_GRANT_DATA);
  assign acq_final   = (state == S_ACQ_D) && tl_d_valid_i &&
                       ((tl_d_opcode_i == D_GRANT) || (acq_beat_wr && beat == 3'd7));
  assign acq_grant_t = ({1'b0, tl_d_param_i} == CAP_TOT) && !tl_d_denied_i;
  // The final data beat and the pending store can target the same word in one cycle.
  assign acq_base    = (acq_beat_wr && beat == req_word) ? tl_d_data_i : data_q[req_idx][req_word];

  always_comb begin
    prb_present  = (perm_q[prb_idx] != PERM_N) && (tag_q[prb_idx] == prb_tag);
    prb_report   = R_NTON;
    prb_new_perm = perm_q[prb_idx];
    if (prb_present) begin
      if (perm_q[prb_idx] == PERM_T)
        prb_report = (prb_param == CAP_TOT) ? R_TTOT : (prb_param == CAP_TOB) ? R_TTOB : R_TTON;
      else
        prb_report = (prb_param == CAP_TON) ? R_BTON : R_BTOB;
      if (prb_param == CAP_TON)
        prb_new_perm = PERM_N;
      else if (prb_param == CAP_TOB && perm_q[prb_idx] == PERM_T)
        prb_new_perm = PERM_B;
    end
  end

  always_comb begin
    gnt_o          = 1'b0;
    tl_b_ready_o   = 1'b0;
    tl_d_ready_o   = 1'b0;
    tl_a_valid_o   = 1'b0;
    tl_a_opcode_o  = 3'd0;
    tl_a_param_o   = 3'd0;
    tl_a_size_o    = 4'd0;
    tl_a_source_o  = 4'd0;
    tl_a_address_o = 64'd0;
    tl_a_mask_o    = 8'd0;
    tl_a_data_o    = 64'd0;
    tl_a_corrupt_o = 1'b0;
    tl_c_valid_o   = 1'b0;
    tl_c_opcode_o  = 3'd0;
    tl_c_param_o   = 3'd0;
    tl_c_size_o    = 4'd0;
    tl_c_source_o  = 4'd0;
    tl_c_address_o = 64'd0;
    tl_c_data_o    = 64'd0;
    tl_c_corrupt_o = 1'b0;
    tl_e_valid_o   = 1'b0;
    tl_e_sink_o    = 4'd0;
    c_has_data     = 1'b0;
    case (state)
      S_IDLE: begin
        tl_b_ready_o = tl_b_valid_i;
        gnt_o        = !tl_b_valid_i && !invalidate_all_i && req_i;
      end
      S_EVICT_C: begin
        tl_c_valid_o   = 1'b1;
        tl_c_size_o    = XFER_SIZE;
        tl_c_source_o  = SOURCE_ID;
        tl_c_address_o = {tag_q[req_idx], req_idx, 6'd0};
        // Only a T line can be dirty, so dirty victims always release TtoN with data.
        c_has_data     = dirty_q[req_idx];
        tl_c_opcode_o  = c_has_data ? C_RELEASE_DATA : C_RELEASE;
        tl_c_param_o   = (perm_q[req_idx] == PERM_T) ? R_TTON : R_BTON;
        tl_c_data_o    = c_has_data ? data_q[req_idx][beat] : 64'd0;
      end
      S_EVICT_WAIT_D: tl_d_ready_o = 1'b1;
      S_ACQ_A: begin
        tl_a_valid_o   = 1'b1;
        tl_a_opcode_o  = A_ACQUIRE_BLOCK;
        tl_a_size_o    = XFER_SIZE;
        tl_a_source_o  = SOURCE_ID;
        tl_a_address_o = {req_addr[63:6], 6'd0};
        tl_a_mask_o    = 8'hFF;
        if (!req_we)
          tl_a_param_o = G_NTOB;
        else if (perm_q[req_idx] == PERM_B && tag_q[req_idx] == req_tag)
          tl_a_param_o = G_BTOT;
        else
          tl_a_param_o = G_NTOT;
      end
      S_ACQ_D: tl_d_ready_o = 1'b1;
      S_GRANT_E: begin
        tl_e_valid_o = 1'b1;
        tl_e_sink_o  = grant_sink;
      end
      S_PROBE_C: begin
        tl_c_valid_o   = 1'b1;
        tl_c_size_o    = XFER_SIZE;
        tl_c_source_o  = prb_source;
        tl_c_address_o = prb_addr;
        c_has_data     = prb_present && dirty_q[prb_idx];
        tl_c_opcode_o  = c_has_data ? C_PROBE_ACK_DATA : C_PROBE_ACK;
        tl_c_param_o   = prb_report;
        tl_c_data_o    = c_has_data ? data_q[prb_idx][beat] : 64'd0;
      end
      default: ;
    endcase
  end

  assign c_last = !c_has_data || (beat == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      beat         <= 3'd0;
      rvalid_o     <= 1'b0;
      rdata_o      <= 64'd0;
      req_we       <= 1'b0;
      req_be       <= 8'd0;
      req_addr     <= 64'd0;
      req_wdata    <= 64'd0;
      prb_param    <= 3'd0;
      prb_source   <= 4'd0;
      prb_addr     <= 64'd0;
      grant_sink   <= 4'd0;
      grant_denied <= 1'b0;
      dirty_q      <= '0;
      for (int i = 0; i < SETS; i++) perm_q[i] <= PERM_N;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          beat <= 3'd0;
          if (tl_b_valid_i) begin
            prb_param  <= tl_b_param_i;
            prb_source <= tl_b_source_i;
            prb_addr   <= tl_b_address_i;
            state      <= S_PROBE_C;
          end else if (invalidate_all_i) begin
            dirty_q <= '0;
            for (int i = 0; i < SETS; i++) perm_q[i] <= PERM_N;
          end else if (req_i) begin
            req_we    <= we_i;
            req_be    <= be_i;
            req_addr  <= addr_i;
            req_wdata <= wdata_i;
            if (in_hit) begin
              rvalid_o <= 1'b1;
              rdata_o  <= data_q[in_idx][addr_i[5:3]];
              if (we_i) dirty_q[in_idx] <= 1'b1;
            end else if (in_victim) begin
              state <= S_EVICT_C;
            end else begin
              state <= S_ACQ_A;
            end
          end
        end
        S_EVICT_C: if (tl_c_ready_i) begin
          beat <= c_last ? 3'd0 : beat + 3'd1;
          if (c_last) state <= S_EVICT_WAIT_D;
        end
        S_EVICT_WAIT_D: if (tl_d_valid_i && tl_d_opcode_i == D_RELEASE_ACK) begin
          perm_q[req_idx]  <= PERM_N;
          dirty_q[req_idx] <= 1'b0;
          state            <= S_ACQ_A;
        end
        S_ACQ_A: if (tl_a_ready_i) begin
          beat  <= 3'd0;
          state <= S_ACQ_D;
        end
        S_ACQ_D: begin
          if (acq_beat_wr) beat <= beat + 3'd1;
          if (acq_final) begin
            grant_sink       <= tl_d_sink_i;
            grant_denied     <= tl_d_denied_i;
            perm_q[req_idx]  <= tl_d_denied_i ? PERM_N : (acq_grant_t ? PERM_T : PERM_B);
            dirty_q[req_idx] <= req_we && acq_grant_t;
            state            <= S_GRANT_E;
          end
        end
        S_GRANT_E: if (tl_e_ready_i) begin
          rvalid_o <= 1'b1;
          rdata_o  <= grant_denied ? 64'd0 : data_q[req_idx][req_word];
          state    <= S_RESP;
        end
        S_RESP: state <= S_IDLE;
        S_PROBE_C: if (tl_c_ready_i) begin
          beat <= c_last ? 3'd0 : beat + 3'd1;
          if (c_last) begin
            if (prb_present) begin
              perm_q[prb_idx]  <= prb_new_perm;
              dirty_q[prb_idx] <= 1'b0;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; validity lives entirely in perm_q.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (gnt_o && in_hit && we_i)
        data_q[in_idx][addr_i[5:3]] <= merge(data_q[in_idx][addr_i[5:3]], wdata_i, be_i);
      if (acq_beat_wr)
        data_q[req_idx][beat] <= tl_d_data_i;
      if (acq_final) begin
        tag_q[req_idx] <= req_tag;
        if (req_we && acq_grant_t)
          data_q[req_idx][req_word] <= merge(acq_base, req_wdata, req_be);
      end
    end
  end

endmodule

// File: tb/tb_rv64g_l1_dcache.sv
// tb/tb_rv64g_l1_dcache.sv - Directed bench for rv64g_l1_dcache: refill, probe, evict, upgrade, denied grant.
module tb_rv64g_l1_dcache;

  logic        clk, rst_n, invalidate_all_i;
  logic        req_i, we_i;
  logic [7:0]  be_i;
  logic [63:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o;
  logic [63:0] rdata_o;
  logic        tl_a_valid_o, tl_a_ready_i;
  logic [2:0]  tl_a_opcode_o, tl_a_param_o;
  logic [3:0]  tl_a_size_o, tl_a_source_o;
  logic [63:0] tl_a_address_o, tl_a_data_o;
  logic [7:0]  tl_a_mask_o;
  logic        tl_a_corrupt_o;
  logic        tl_b_valid_i, tl_b_ready_o;
  logic [2:0]  tl_b_opcode_i, tl_b_param_i;
  logic [3:0]  tl_b_size_i, tl_b_source_i;
  logic [63:0] tl_b_address_i, tl_b_data_i;
  logic [7:0]  tl_b_mask_i;
  logic        tl_b_corrupt_i;
  logic        tl_c_valid_o, tl_c_ready_i;
  logic [2:0]  tl_c_opcode_o, tl_c_param_o;
  logic [3:0]  tl_c_size_o, tl_c_source_o;
  logic [63:0] tl_c_address_o, tl_c_data_o;
  logic        tl_c_corrupt_o;
  logic        tl_d_valid_i, tl_d_ready_o;
  logic [2:0]  tl_d_opcode_i;
  logic [1:0]  tl_d_param_i;
  logic [3:0]  tl_d_size_i, tl_d_source_i, tl_d_sink_i;
  logic        tl_d_denied_i, tl_d_corrupt_i;
  logic [63:0] tl_d_data_i;
  logic        tl_e_valid_o, tl_e_ready_i;
  logic [3:0]  tl_e_sink_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_beats [8];

  rv64g_l1_dcache #(.SETS(64), .SOURCE_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .invalidate_all_i(invalidate_all_i),
    .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .tl_a_valid_o(tl_a_valid_o), .tl_a_ready_i(tl_a_ready_i), .tl_a_opcode_o(tl_a_opcode_o),
    .tl_a_param_o(tl_a_param_o), .tl_a_size_o(tl_a_size_o), .tl_a_source_o(tl_a_source_o),
    .tl_a_address_o(tl_a_address_o), .tl_a_mask_o(tl_a_mask_o), .tl_a_data_o(tl_a_data_o),
    .tl_a_corrupt_o(tl_a_corrupt_o),
    .tl_b_valid_i(tl_b_valid_i), .tl_b_ready_o(tl_b_ready_o), .tl_b_opcode_i(tl_b_opcode_i),
    .tl_b_param_i(tl_b_param_i), .tl_b_size_i(tl_b_size_i), .tl_b_source_i(tl_b_source_i),
    .tl_b_address_i(tl_b_address_i), .tl_b_mask_i(tl_b_mask_i), .tl_b_data_i(tl_b_data_i),
    .tl_b_corrupt_i(tl_b_corrupt_i),
    .tl_c_valid_o(tl_c_valid_o), .tl_c_ready_i(tl_c_ready_i), .tl_c_opcode_o(tl_c_opcode_o),
    .tl_c_param_o(tl_c_param_o), .tl_c_size_o(tl_c_size_o), .tl_c_source_o(tl_c_source_o),
    .tl_c_address_o(tl_c_address_o), .tl_c_data_o(tl_c_data_o), .tl_c_corrupt_o(tl_c_corrupt_o),
    .tl_d_valid_i(tl_d_valid_i), .tl_d_ready_o(tl_d_ready_o), .tl_d_opcode_i(tl_d_opcode_i),
    .tl_d_param_i(tl_d_param_i), .tl_d_size_i(tl_d_size_i), .tl_d_source_i(tl_d_source_i),
    .tl_d_sink_i(tl_d_sink_i), .tl_d_denied_i(tl_d_denied_i), .tl_d_data_i(tl_d_data_i),
    .tl_d_corrupt_i(tl_d_corrupt_i),
    .tl_e_valid_o(tl_e_valid_o), .tl_e_ready_i(tl_e_ready_i), .tl_e_sink_o(tl_e_sink_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_req(input logic we, input logic [7:0] be, input logic [63:0] addr,
                         input logic [63:0] wd);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
    #1;
    chk("gnt", gnt_o, 1);
    step();
    req_i = 1'b0;
  endtask

  task automatic expect_a(input logic [2:0] param, input logic [63:0] addr);
    int n = 0;
    while (!tl_a_valid_o && n < 64) begin step(); n++; end
    chk("a_valid", tl_a_valid_o, 1);
    chk("a_fields", {tl_a_opcode_o, tl_a_param_o, tl_a_size_o, tl_a_source_o, tl_a_mask_o},
        {3'd6, param, 4'd6, 4'd0, 8'hFF});
    chk("a_address", tl_a_address_o, addr);
    tl_a_ready_i = 1'b1;
    step();
    tl_a_ready_i = 1'b0;
  endtask

  task automatic send_d(input logic [2:0] op, input logic [1:0] cap, input logic [3:0] sink,
                        input logic denied, input logic [63:0] base, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      tl_d_valid_i = 1'b1; tl_d_opcode_i = op; tl_d_param_i = cap; tl_d_sink_i = sink;
      tl_d_denied_i = denied; tl_d_data_i = base + 64'(k); tl_d_size_i = 4'd6;
      #1;
      chk("d_ready", tl_d_ready_o, 1);
      step();
    end
    tl_d_valid_i = 1'b0;
  endtask

  task automatic expect_e(input logic [3:0] sink);
    int n = 0;
    while (!tl_e_valid_o && n < 64) begin step(); n++; end
    chk("e_valid", tl_e_valid_o, 1);
    chk("e_sink", tl_e_sink_o, sink);
    tl_e_ready_i = 1'b1;
    step();
    tl_e_ready_i = 1'b0;
  endtask

  task automatic expect_c(input logic [2:0] op, input logic [2:0] param, input logic [3:0] src,
                          input logic [63:0] addr, input int nbeats);
    int n = 0;
    while (!tl_c_valid_o && n < 64) begin step(); n++; end
    chk("c_valid", tl_c_valid_o, 1);
    chk("c_fields", {tl_c_opcode_o, tl_c_param_o, tl_c_size_o, tl_c_source_o, tl_c_corrupt_o},
        {op, param, 4'd6, src, 1'b0});
    chk("c_address", tl_c_address_o, addr);
    for (int k = 0; k < nbeats; k++) begin
      if (nbeats > 1) chk($sformatf("c_beat%0d", k), tl_c_data_o, exp_beats[k]);
      tl_c_ready_i = 1'b1;
      step();
    end
    tl_c_ready_i = 1'b0;
    #1;
    chk("c_done", tl_c_valid_o, 0);
  endtask

  task automatic send_probe(input logic [2:0] cap, input logic [3:0] src, input logic [63:0] addr);
    tl_b_valid_i = 1'b1; tl_b_opcode_i = 3'd6; tl_b_param_i = cap; tl_b_source_i = src;
    tl_b_address_i = addr; tl_b_size_i = 4'd6;
    #1;
    chk("b_ready", tl_b_ready_o, 1);
    step();
    tl_b_valid_i = 1'b0;
  endtask

  task automatic expect_resp(input logic check_data, input logic [63:0] exp);
    chk("rvalid", rvalid_o, 1);
    if (check_data) chk("rdata", rdata_o, exp);
    step();
    chk("rvalid_pulse", rvalid_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; invalidate_all_i = 1'b0;
    req_i = 1'b0; we_i = 1'b0; be_i = 8'h00; addr_i = 64'd0; wdata_i = 64'd0;
    tl_a_ready_i = 1'b0; tl_c_ready_i = 1'b0; tl_e_ready_i = 1'b0;
    tl_b_valid_i = 1'b0; tl_b_opcode_i = 3'd0; tl_b_param_i = 3'd0; tl_b_size_i = 4'd0;
    tl_b_source_i = 4'd0; tl_b_address_i = 64'd0; tl_b_mask_i = 8'h00; tl_b_data_i = 64'd0;
    tl_b_corrupt_i = 1'b0;
    tl_d_valid_i = 1'b0; tl_d_opcode_i = 3'd0; tl_d_param_i = 2'd0; tl_d_size_i = 4'd0;
    tl_d_source_i = 4'd0; tl_d_sink_i = 4'd0; tl_d_denied_i = 1'b0; tl_d_data_i = 64'd0;
    tl_d_corrupt_i = 1'b0;
    step(); step(); step();

    // Reset state
    chk("reset_ctrl", {gnt_o, rvalid_o, tl_a_valid_o, tl_b_ready_o, tl_c_valid_o,
                       tl_d_ready_o, tl_e_valid_o}, 0);
    chk("reset_rdata", rdata_o, 0);
    chk("reset_a_addr", tl_a_address_o, 0);
    rst_n = 1'b1;
    step();

    // Write miss at 0x1000 -> AcquireBlock NtoT, GrantData toT sink 1, GrantAck, rvalid
    cpu_req(1'b1, 8'hFF, 64'h1000, 64'hDEADBEEF);
    expect_a(3'd1, 64'h1000);
    send_d(3'd5, 2'd0, 4'd1, 1'b0, 64'd0, 8);
    expect_e(4'd1);
    expect_resp(1'b0, 64'd0);

    // Probe toN on the dirty T line -> ProbeAckData TtoN
    exp_beats[0] = 64'hDEADBEEF;
    for (int k = 1; k < 8; k++) exp_beats[k] = 64'(k);
    send_probe(3'd2, 4'd2, 64'h1000);
    expect_c(3'd5, 3'd1, 4'd2, 64'h1000, 8);

    // Read after probe -> miss, AcquireBlock NtoB; refill granted toB
    cpu_req(1'b0, 8'hFF, 64'h1000, 64'd0);
    expect_a(3'd0, 64'h1000);
    send_d(3'd5, 2'd1, 4'd3, 1'b0, 64'h100, 8);
    expect_e(4'd3);
    expect_resp(1'b1, 64'h100);

    // Read hit on refilled word 3: one cycle, no A traffic
    cpu_req(1'b0, 8'hFF, 64'h1018, 64'd0);
    chk("hit_no_a", tl_a_valid_o, 0);
    expect_resp(1'b1, 64'h103);

    // Store to B line -> upgrade BtoT, dataless Grant keeps line, partial merge
    cpu_req(1'b1, 8'h0F, 64'h1008, 64'hAAAABBBBCCCCDDDD);
    expect_a(3'd2, 64'h1000);
    send_d(3'd4, 2'd0, 4'd5, 1'b0, 64'd0, 1);
    expect_e(4'd5);
    expect_resp(1'b0, 64'd0);
    cpu_req(1'b0, 8'hFF, 64'h1008, 64'd0);
    expect_resp(1'b1, 64'h00000000CCCCDDDD);
    cpu_req(1'b0, 8'hFF, 64'h1010, 64'd0);
    expect_resp(1'b1, 64'h102);

    // Store to other tag in same set while dirty T -> ReleaseData, ReleaseAck, Acquire NtoT
    exp_beats[0] = 64'h100;
    exp_beats[1] = 64'h00000000CCCCDDDD;
    for (int k = 2; k < 8; k++) exp_beats[k] = 64'h100 + 64'(k);
    cpu_req(1'b1, 8'h01, 64'h2000, 64'h55);
    expect_c(3'd7, 3'd1, 4'd0, 64'h1000, 8);
    chk("evict_wait_d_ready", tl_d_ready_o, 1);
    chk("evict_wait_no_a", tl_a_valid_o, 0);
    send_d(3'd6, 2'd0, 4'd0, 1'b0, 64'd0, 1);
    expect_a(3'd1, 64'h2000);
    send_d(3'd5, 2'd0, 4'd2, 1'b0, 64'h200, 8);
    expect_e(4'd2);
    expect_resp(1'b0, 64'd0);
    cpu_req(1'b0, 8'hFF, 64'h2000, 64'd0);
    expect_resp(1'b1, 64'h255);

    // Probe to an absent line -> single ProbeAck NtoN
    send_probe(3'd2, 4'd7, 64'h3040);
    expect_c(3'd4, 3'd5, 4'd7, 64'h3040, 1);

    // Probe together with req_i: probe wins, gnt held off until ProbeAckData TtoB completes
    req_i = 1'b1; we_i = 1'b0; be_i = 8'hFF; addr_i = 64'h2000;
    tl_b_valid_i = 1'b1; tl_b_opcode_i = 3'd6; tl_b_param_i = 3'd1; tl_b_source_i = 4'd4;
    tl_b_address_i = 64'h2000;
    #1;
    chk("race_gnt", gnt_o, 0);
    chk("race_b_ready", tl_b_ready_o, 1);
    step();
    tl_b_valid_i = 1'b0;
    chk("race_gnt_probe", gnt_o, 0);
    exp_beats[0] = 64'h255;
    for (int k = 1; k < 8; k++) exp_beats[k] = 64'h200 + 64'(k);
    expect_c(3'd5, 3'd0, 4'd4, 64'h2000, 8);
    chk("race_gnt_after", gnt_o, 1);
    step();
    req_i = 1'b0;
    expect_resp(1'b1, 64'h255);

    // Store miss on clean B victim -> Release BtoN; denied Grant leaves line N, rdata 0
    cpu_req(1'b1, 8'hFF, 64'h1000, 64'h77);
    expect_c(3'd6, 3'd2, 4'd0, 64'h2000, 1);
    send_d(3'd6, 2'd0, 4'd0, 1'b0, 64'd0, 1);
    expect_a(3'd1, 64'h1000);
    send_d(3'd4, 2'd0, 4'd6, 1'b1, 64'd0, 1);
    expect_e(4'd6);
    expect_resp(1'b1, 64'd0);

    // Line is N after denial: read misses; reset mid-acquire aborts
    cpu_req(1'b0, 8'hFF, 64'h1000, 64'd0);
    chk("denied_refetch_a", tl_a_valid_o, 1);
    chk("denied_refetch_param", tl_a_param_o, 3'd0);
    rst_n = 1'b0;
    step();
    chk("abort_a_valid", tl_a_valid_o, 0);
    chk("abort_d_ready", tl_d_ready_o, 0);
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
